// File: rtl/userid_lookup.sv
// rtl/userid_lookup.sv - user-ID ROM scan with grant session, failure counting and lockout
// Outputs are decoded from state so the async reset clears them immediately.
module userid_lookup #(
   parameter  int ID_W     = 16,
   parameter  int ADDR_W   = 4,
   parameter  int DEPTH    = 16,
   parameter  int ROM_LAT  = 2,
   parameter  int MAX_FAIL = 3,
   localparam int FC_W     = $clog2(MAX_FAIL + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   input  logic [ID_W-1:0]   userid_entered,
   input  logic [ID_W-1:0]   rom_userid,
   input  logic              logout,
   input  logic              unlock,
   output logic [ADDR_W-1:0] address,
   output logic [ADDR_W-1:0] internalid,
   output logic              access_rom,
   output logic              busy,
   output logic              not_found,
   output logic              locked,
   output logic [FC_W-1:0]   fail_count
);

   localparam int WC_W = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   localparam logic [WC_W-1:0]   LAT  = WC_W'(ROM_LAT);
   localparam logic [WC_W-1:0]   ONE  = WC_W'(1);
   localparam logic [FC_W-1:0]   FMAX = FC_W'(MAX_FAIL);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_CMP   = 3'd2,
      S_DENY  = 3'd3,
      S_GRANT = 3'd4,
      S_LOCK  = 3'd5
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ID_W-1:0]   key;
   logic [WC_W-1:0]   wait_cnt;
   logic              match;
   logic [FC_W-1:0]   fc_inc;

   assign match  = (key == rom_userid);
   assign fc_inc = (fail_count == FMAX) ? fail_count : fail_count + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (valid) state_nxt = S_WAIT;
         S_WAIT:  if (wait_cnt <= ONE) state_nxt = S_CMP;
         S_CMP: begin
            if (match)                 state_nxt = S_GRANT;
            else if (address == LAST)  state_nxt = S_DENY;
            else                       state_nxt = S_WAIT;
         end
         S_DENY:  state_nxt = (fc_inc == FMAX) ? S_LOCK : S_IDLE;
         S_GRANT: if (logout) state_nxt = S_IDLE;
         S_LOCK:  if (unlock) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      not_found  = 1'b0;
      access_rom = 1'b0;
      locked     = 1'b0;
      case (state)
         S_WAIT, S_CMP: busy       = 1'b1;
         S_DENY:        not_found  = 1'b1;
         S_GRANT:       access_rom = 1'b1;
         S_LOCK:        locked     = 1'b1;
         default: ;
      endcase
   end

   // Address is parked at 0 whenever the block returns to IDLE so the ROM is pre-read for the next scan.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key        <= '0;
         wait_cnt   <= '0;
         address    <= '0;
         internalid <= '0;
         fail_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               address    <= '0;
               internalid <= '0;
               if (valid) begin
                  key      <= userid_entered;
                  wait_cnt <= LAT;
               end
            end
            S_WAIT: wait_cnt <= wait_cnt - 1'b1;
            S_CMP: begin
               if (match) begin
                  internalid <= address;
                  fail_count <= '0;
               end else if (address != LAST) begin
                  address  <= address + 1'b1;
                  wait_cnt <= LAT;
               end
            end
            S_DENY: begin
               fail_count <= fc_inc;
               address    <= '0;
            end
            S_GRANT: begin
               if (logout) begin
                  internalid <= '0;
                  address    <= '0;
               end
            end
            S_LOCK: if (unlock) fail_count <= '0;
            default: begin
               address    <= '0;
               internalid <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_userid_lookup.sv
// tb/tb_userid_lookup.sv - scoreboard bench for userid_lookup
// Stimulus queues timed expectations and events; the monitor pops and compares on each falling edge.
module tb_userid_lookup;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        valid, logout, unlock;
   logic [15:0] uid, rom_data;
   logic [3:0]  address, internalid;
   logic        access_rom, busy, not_found, locked;
   logic [1:0]  fail_count;

   logic        valid2;
   logic [15:0] uid2;
   logic [15:0] rom_data2;
   logic [3:0]  address2, internalid2;
   logic        access_rom2, busy2, not_found2, locked2;
   logic [1:0]  fail_count2;

   logic [15:0] rom [16];
   logic [3:0]  a_d1 = 4'd0;
   logic [3:0]  a_d2 = 4'd0;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   bit done = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Two-cycle ROM: data follows address after ROM_LAT edges.
   always @(posedge clk) begin
      a_d1 <= address;
      a_d2 <= a_d1;
   end
   assign rom_data  = rom[a_d2];
   assign rom_data2 = 16'h1111;

   userid_lookup dut (
      .clk(clk), .reset(reset), .valid(valid), .userid_entered(uid),
      .rom_userid(rom_data), .logout(logout), .unlock(unlock),
      .address(address), .internalid(internalid), .access_rom(access_rom),
      .busy(busy), .not_found(not_found), .locked(locked), .fail_count(fail_count)
   );

   userid_lookup #(.DEPTH(1)) dut2 (
      .clk(clk), .reset(reset), .valid(valid2), .userid_entered(uid2),
      .rom_userid(rom_data2), .logout(1'b0), .unlock(1'b0),
      .address(address2), .internalid(internalid2), .access_rom(access_rom2),
      .busy(busy2), .not_found(not_found2), .locked(locked2), .fail_count(fail_count2)
   );

   typedef struct {
      int    cyc;
      int    sel;
      int    exp;
      string name;
   } vchk_t;

   typedef struct {
      int cyc;
      int kind;
      int id;
   } ev_t;

   vchk_t vq[$];
   ev_t   eq[$];

   localparam int S_ADDR = 0, S_IID = 1, S_ACC = 2, S_BUSY = 3, S_NF = 4;
   localparam int S_LCK = 5, S_FC = 6, S_ADDR2 = 7, S_NF2 = 8;
   localparam int E_GRANT = 0, E_DENY = 1, E_DENY2 = 2;

   task automatic expect_at(input int c, input int sel, input int exp, input string name);
      vchk_t v;
      v.cyc = c; v.sel = sel; v.exp = exp; v.name = name;
      vq.push_back(v);
   endtask

   task automatic expect_ev(input int c, input int kind, input int id);
      ev_t e;
      e.cyc = c; e.kind = kind; e.id = id;
      eq.push_back(e);
   endtask

   function automatic int sample(input int sel);
      case (sel)
         S_ADDR:  return int'(address);
         S_IID:   return int'(internalid);
         S_ACC:   return int'(access_rom);
         S_BUSY:  return int'(busy);
         S_NF:    return int'(not_found);
         S_LCK:   return int'(locked);
         S_FC:    return int'(fail_count);
         S_ADDR2: return int'(address2);
         S_NF2:   return int'(not_found2);
         default: return -1;
      endcase
   endfunction

   task automatic check_event(input int kind, input int id);
      ev_t e;
      checks++;
      if (eq.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event cycle %0d: actual kind %0d id %0d required none", cyc, kind, id);
      end else begin
         e = eq.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.id != id) begin
            errors++;
            $display("FAIL event: actual kind %0d cycle %0d id %0d required kind %0d cycle %0d id %0d",
                     kind, cyc, id, e.kind, e.cyc, e.id);
         end
      end
   endtask

   initial begin : monitor
      bit acc_prev;
      acc_prev = 1'b0;
      forever begin
         @(negedge clk);
         for (int i = vq.size() - 1; i >= 0; i--) begin
            if (vq[i].cyc == cyc) begin
               checks++;
               if (sample(vq[i].sel) != vq[i].exp) begin
                  errors++;
                  $display("FAIL %s cycle %0d: actual %0d required %0d",
                           vq[i].name, cyc, sample(vq[i].sel), vq[i].exp);
               end
               vq.delete(i);
            end
         end
         if (access_rom && !acc_prev) check_event(E_GRANT, int'(internalid));
         if (not_found)  check_event(E_DENY, 0);
         if (not_found2) check_event(E_DENY2, 0);
         acc_prev = access_rom;
         if (done || cyc > 6000) begin
            checks++;
            if (!done) begin
               errors++;
               $display("FAIL timeout: actual cycle %0d required stimulus complete", cyc);
            end
            checks++;
            if (vq.size() != 0 || eq.size() != 0) begin
               errors++;
               $display("FAIL pending: actual %0d values %0d events left required 0", vq.size(), eq.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   task automatic miss(input int m, input bit check_lock);
      int b;
      b = cyc;
      valid = 1'b1;
      uid   = 16'hDEAD;
      expect_at(b + 48, S_NF, 0, "miss_nf_before");
      expect_at(b + 49, S_NF, 1, "miss_nf");
      expect_at(b + 50, S_NF, 0, "miss_nf_after");
      expect_at(b + 49, S_ADDR, 15, "miss_last_addr");
      expect_at(b + 49, S_BUSY, 0, "miss_busy");
      expect_at(b + 50, S_ADDR, 0, "miss_addr_idle");
      expect_at(b + 50, S_FC, m, "miss_fail_count");
      if (check_lock) expect_at(b + 50, S_LCK, (m == 3) ? 1 : 0, "miss_locked");
      expect_ev(b + 49, E_DENY, 0);
      @(negedge clk);
      valid = 1'b0;
      repeat (50) @(negedge clk);
   endtask

   task automatic hit0_and_logout(input int fc_before);
      int b;
      b = cyc;
      valid = 1'b1;
      uid   = 16'h1000;
      expect_at(b + 3, S_ACC, 0, "hit0_acc_before");
      expect_at(b + 4, S_ACC, 1, "hit0_acc");
      expect_at(b + 4, S_IID, 0, "hit0_iid");
      expect_at(b + 3, S_FC, fc_before, "hit0_fc_before");
      expect_at(b + 4, S_FC, 0, "hit0_fc");
      expect_ev(b + 4, E_GRANT, 0);
      @(negedge clk);
      valid = 1'b0;
      repeat (5) @(negedge clk);
      logout = 1'b1;
      @(negedge clk);
      logout = 1'b0;
      @(negedge clk);
   endtask

   initial begin : stimulus
      int b;
      valid = 1'b0; uid = '0; logout = 1'b0; unlock = 1'b0;
      valid2 = 1'b0; uid2 = '0;
      for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i);
      rom[5]  = 16'hBEEF;
      rom[15] = 16'hCAFE;

      @(negedge clk);
      b = cyc;
      expect_at(b + 1, S_ADDR, 0, "rst_addr");
      expect_at(b + 1, S_IID, 0, "rst_iid");
      expect_at(b + 1, S_ACC, 0, "rst_acc");
      expect_at(b + 1, S_BUSY, 0, "rst_busy");
      expect_at(b + 1, S_NF, 0, "rst_nf");
      expect_at(b + 1, S_LCK, 0, "rst_locked");
      expect_at(b + 1, S_FC, 0, "rst_fc");
      expect_at(b + 1, S_ADDR2, 0, "rst_addr2");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Hit on entry 5; the entered ID changes to entry 3's value after acceptance.
      b = cyc;
      valid = 1'b1;
      uid   = 16'hBEEF;
      for (int k = 0; k <= 5; k++) expect_at(b + 3 * k + 2, S_ADDR, k, "hit_addr_step");
      expect_at(b + 1, S_BUSY, 1, "hit_busy_start");
      expect_at(b + 18, S_BUSY, 1, "hit_busy_cmp");
      expect_at(b + 19, S_BUSY, 0, "hit_busy_end");
      expect_at(b + 18, S_ACC, 0, "hit_acc_before");
      expect_at(b + 19, S_ACC, 1, "hit_acc");
      expect_at(b + 19, S_IID, 5, "hit_iid");
      expect_at(b + 25, S_ACC, 1, "hit_acc_held");
      expect_at(b + 26, S_ACC, 0, "logout_acc");
      expect_at(b + 26, S_IID, 0, "logout_iid");
      expect_ev(b + 19, E_GRANT, 5);
      @(negedge clk);
      valid = 1'b0;
      uid   = 16'h1003;
      repeat (7) @(negedge clk);
      logout = 1'b1;
      unlock = 1'b1;
      @(negedge clk);
      logout = 1'b0;
      unlock = 1'b0;
      repeat (16) @(negedge clk);
      logout = 1'b1;
      @(negedge clk);
      logout = 1'b0;
      repeat (2) @(negedge clk);

      // Three misses lead to lockout.
      for (int m = 1; m <= 3; m++) miss(m, 1'b1);

      b = cyc;
      valid = 1'b1;
      uid   = 16'h1000;
      expect_at(b + 1, S_BUSY, 0, "lock_valid_busy");
      expect_at(b + 4, S_BUSY, 0, "lock_valid_busy_late");
      expect_at(b + 4, S_LCK, 1, "lock_held");
      expect_at(b + 4, S_FC, 3, "lock_fc");
      @(negedge clk);
      valid = 1'b0;
      repeat (4) @(negedge clk);

      b = cyc;
      unlock = 1'b1;
      expect_at(b + 1, S_LCK, 0, "unlock_locked");
      expect_at(b + 1, S_FC, 0, "unlock_fc");
      @(negedge clk);
      unlock = 1'b0;
      hit0_and_logout(0);

      // Failure count clears on a hit.
      miss(1, 1'b0);
      miss(2, 1'b0);
      hit0_and_logout(2);

      // Match only at the last entry.
      b = cyc;
      valid = 1'b1;
      uid   = 16'hCAFE;
      expect_at(b + 48, S_ACC, 0, "last_acc_before");
      expect_at(b + 48, S_ADDR, 15, "last_addr");
      expect_at(b + 49, S_IID, 15, "last_iid");
      expect_ev(b + 49, E_GRANT, 15);
      @(negedge clk);
      valid = 1'b0;
      repeat (50) @(negedge clk);
      logout = 1'b1;
      @(negedge clk);
      logout = 1'b0;
      @(negedge clk);

      // Single-entry table, mismatch.
      b = cyc;
      valid2 = 1'b1;
      uid2   = 16'h2222;
      expect_at(b + 3, S_NF2, 0, "d1_nf_before");
      expect_at(b + 4, S_NF2, 1, "d1_nf");
      expect_at(b + 5, S_NF2, 0, "d1_nf_after");
      for (int c = 1; c <= 5; c++) expect_at(b + c, S_ADDR2, 0, "d1_addr");
      expect_ev(b + 4, E_DENY2, 0);
      @(negedge clk);
      valid2 = 1'b0;
      repeat (6) @(negedge clk);

      // Asynchronous reset while waiting on entry 3.
      b = cyc;
      valid = 1'b1;
      uid   = 16'hDEAD;
      expect_at(b + 11, S_ADDR, 3, "mid_addr");
      expect_at(b + 11, S_BUSY, 1, "mid_busy");
      expect_at(b + 12, S_ADDR, 0, "arst_addr");
      expect_at(b + 12, S_BUSY, 0, "arst_busy");
      expect_at(b + 12, S_ACC, 0, "arst_acc");
      expect_at(b + 12, S_NF, 0, "arst_nf");
      expect_at(b + 12, S_LCK, 0, "arst_locked");
      expect_at(b + 12, S_FC, 0, "arst_fc");
      @(negedge clk);
      valid = 1'b0;
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      hit0_and_logout(0);
      repeat (3) @(negedge clk);
      done = 1'b1;
   end

endmodule
